// File: rtl/thermo_demand_gen.sv
// Thermostat front end: moving-average filter, hysteresis FSM and minimum-dwell
// counter producing heat/cool demand (A/B) and the latched mode bit (status).
module thermo_demand_gen #(
  parameter int TEMP_W    = 12,
  parameter int HYST      = 32,
  parameter int AVG_LOG2  = 2,
  parameter int MIN_DWELL = 8
) (
  input  logic              clock,
  input  logic              rst,
  input  logic [TEMP_W-1:0] temp_in,
  input  logic              temp_valid,
  input  logic [TEMP_W-1:0] target,
  input  logic              mode_in,
  output logic [TEMP_W-1:0] filt_temp,
  output logic              filt_valid,
  output logic              A,
  output logic              B,
  output logic              status
);

  localparam int WIN   = 1 << AVG_LOG2;
  localparam int SUM_W = TEMP_W + AVG_LOG2;
  localparam int CMP_W = TEMP_W + 1;
  localparam int DW_W  = $clog2(MIN_DWELL + 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HEAT = 2'd1;
  localparam logic [1:0] ST_COOL = 2'd2;

  logic [TEMP_W-1:0]       win_q [WIN];
  logic [TEMP_W-1:0]       win_d [WIN];
  logic                    primed_q;
  logic signed [SUM_W-1:0] sum_q, sum_d;
  logic signed [SUM_W-1:0] sample_ext, oldest_ext;
  logic [TEMP_W-1:0]       filt_q;
  logic                    filt_valid_q;

  logic [1:0]              state_q, state_d;
  logic [DW_W-1:0]         dwell_q, dwell_d;
  logic                    status_q, status_d;

  assign sample_ext = {{AVG_LOG2{temp_in[TEMP_W-1]}}, temp_in};
  assign oldest_ext = {{AVG_LOG2{win_q[WIN-1][TEMP_W-1]}}, win_q[WIN-1]};

  // The first sample after reset fills the whole window so the average starts at it.
  always_comb begin
    if (primed_q) begin
      sum_d    = sum_q + sample_ext - oldest_ext;
      win_d[0] = temp_in;
      for (int unsigned i = 1; i < WIN; i++) win_d[i] = win_q[i-1];
    end else begin
      sum_d = sample_ext <<< AVG_LOG2;
      for (int unsigned i = 0; i < WIN; i++) win_d[i] = temp_in;
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      for (int unsigned i = 0; i < WIN; i++) win_q[i] <= '0;
      primed_q     <= 1'b0;
      sum_q        <= '0;
      filt_q       <= '0;
      filt_valid_q <= 1'b0;
    end else begin
      filt_valid_q <= temp_valid;
      if (temp_valid) begin
        for (int unsigned i = 0; i < WIN; i++) win_q[i] <= win_d[i];
        primed_q <= 1'b1;
        sum_q    <= sum_d;
        // Upper TEMP_W bits of the sum are the arithmetic shift right by AVG_LOG2.
        filt_q   <= sum_d[AVG_LOG2 +: TEMP_W];
      end
    end
  end

  logic signed [CMP_W-1:0] filt_c, tgt_c, hyst_c;
  logic                    dwell_ok;

  assign filt_c   = {filt_q[TEMP_W-1], filt_q};
  assign tgt_c    = {target[TEMP_W-1], target};
  assign hyst_c   = CMP_W'(HYST);
  assign dwell_ok = (dwell_q == DW_W'(MIN_DWELL));

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (filt_valid_q && dwell_ok) begin
          if (!status_q && (filt_c + hyst_c <= tgt_c))     state_d = ST_HEAT;
          else if (status_q && (filt_c >= tgt_c + hyst_c)) state_d = ST_COOL;
        end
      end
      ST_HEAT: begin
        if (filt_valid_q && (mode_in || (dwell_ok && filt_c >= tgt_c)))  state_d = ST_IDLE;
      end
      ST_COOL: begin
        if (filt_valid_q && (!mode_in || (dwell_ok && filt_c <= tgt_c))) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    dwell_d = dwell_q;
    if (filt_valid_q) begin
      if (state_d != state_q) dwell_d = '0;
      else if (!dwell_ok)     dwell_d = dwell_q + DW_W'(1);
    end

    status_d = (state_q == ST_IDLE) ? mode_in : status_q;
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      dwell_q  <= DW_W'(MIN_DWELL);
      status_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      dwell_q  <= dwell_d;
      status_q <= status_d;
    end
  end

  assign filt_temp  = filt_q;
  assign filt_valid = filt_valid_q;
  assign A          = (state_q == ST_HEAT);
  assign B          = (state_q == ST_COOL);
  assign status     = status_q;

endmodule

// File: tb/tb_thermo_demand_gen.sv
// Directed bench for thermo_demand_gen: hand-computed filter values, FSM
// transitions, dwell gating, forced exit, reset behaviour and compare range.
module tb_thermo_demand_gen;

  logic        clock = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] temp_in = '0;
  logic        temp_valid = 1'b0;
  logic [11:0] target = '0;
  logic        mode_in = 1'b0;
  logic [11:0] filt_temp;
  logic        filt_valid, A, B, status;

  int n_checks = 0;
  int n_pass   = 0;

  thermo_demand_gen #(.TEMP_W(12), .HYST(32), .AVG_LOG2(2), .MIN_DWELL(8)) dut (
    .clock      (clock),
    .rst        (rst),
    .temp_in    (temp_in),
    .temp_valid (temp_valid),
    .target     (target),
    .mode_in    (mode_in),
    .filt_temp  (filt_temp),
    .filt_valid (filt_valid),
    .A          (A),
    .B          (B),
    .status     (status)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    temp_valid = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  // Drive one sample; on return filt_temp/filt_valid for it are visible.
  task automatic sample(input logic [11:0] v);
    temp_in = v;
    temp_valid = 1'b1;
    tick();
    temp_valid = 1'b0;
  endtask

  initial begin
    // 1: cooling, immediate entry into COOL
    mode_in = 1'b1;
    target  = 12'h120;
    do_reset();
    check("rst_A", {15'd0, A}, 16'd0);
    check("rst_B", {15'd0, B}, 16'd0);
    check("rst_status", {15'd0, status}, 16'd0);
    check("rst_filt", {4'd0, filt_temp}, 16'h000);
    check("rst_fvalid", {15'd0, filt_valid}, 16'd0);
    tick();
    sample(12'h1A0);
    check("t1_filt", {4'd0, filt_temp}, 16'h1A0);
    check("t1_fvalid", {15'd0, filt_valid}, 16'd1);
    check("t1_B_early", {15'd0, B}, 16'd0);
    tick();
    check("t1_B", {15'd0, B}, 16'd1);
    check("t1_A", {15'd0, A}, 16'd0);
    check("t1_status", {15'd0, status}, 16'd1);
    check("t1_fvalid_pulse", {15'd0, filt_valid}, 16'd0);

    // 2: cooling down; dwell holds B until the 9th evaluation after entry
    for (int k = 1; k <= 9; k++) begin
      repeat (8) tick();
      sample(12'h110);
      if (k == 1) check("t2_filt1", {4'd0, filt_temp}, 16'h17C);
      if (k == 4) check("t2_filt4", {4'd0, filt_temp}, 16'h110);
      tick();
      check($sformatf("t2_B_eval%0d", k), {15'd0, B}, (k <= 8) ? 16'd1 : 16'd0);
    end

    // 3: heating; inside band stays idle, 0x120 steady enters HEAT
    mode_in = 1'b0;
    target  = 12'h140;
    do_reset();
    for (int k = 1; k <= 3; k++) begin
      sample(12'h130);
      tick();
      check($sformatf("t3_A_band%0d", k), {15'd0, A}, 16'd0);
    end
    for (int k = 1; k <= 4; k++) begin
      sample(12'h120);
      if (k == 1) check("t3_filt1", {4'd0, filt_temp}, 16'h12C);
      tick();
      check($sformatf("t3_A_s%0d", k), {15'd0, A}, (k == 4) ? 16'd1 : 16'd0);
    end

    // 4: jump hot while in HEAT; dwell holds A
    for (int k = 1; k <= 9; k++) begin
      repeat (3) tick();
      sample(12'h190);
      if (k == 2) check("t4_filt2", {4'd0, filt_temp}, 16'h158);
      tick();
      check($sformatf("t4_A_eval%0d", k), {15'd0, A}, (k <= 8) ? 16'd1 : 16'd0);
    end

    // 5: forced exit from HEAT on mode change, status follows a cycle later
    mode_in = 1'b0;
    target  = 12'h140;
    do_reset();
    sample(12'h120);
    tick();
    check("t5_A_enter", {15'd0, A}, 16'd1);
    repeat (3) tick();
    mode_in = 1'b1;
    sample(12'h120);
    tick();
    check("t5_A_forced", {15'd0, A}, 16'd0);
    check("t5_B_forced", {15'd0, B}, 16'd0);
    check("t5_status_frozen", {15'd0, status}, 16'd0);
    tick();
    check("t5_status_late", {15'd0, status}, 16'd1);

    // 6: reset mid-COOL, simultaneous sample dropped, then re-prime
    mode_in = 1'b1;
    target  = 12'h120;
    do_reset();
    tick();
    sample(12'h1A0);
    tick();
    check("t6_B_cool", {15'd0, B}, 16'd1);
    temp_in = 12'h1A0;
    temp_valid = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    temp_valid = 1'b0;
    check("t6_B_rst", {15'd0, B}, 16'd0);
    check("t6_filt_rst", {4'd0, filt_temp}, 16'h000);
    check("t6_fvalid_rst", {15'd0, filt_valid}, 16'd0);
    check("t6_status_rst", {15'd0, status}, 16'd0);
    tick();
    check("t6_fvalid_drop", {15'd0, filt_valid}, 16'd0);
    sample(12'h0F0);
    check("t6_filt_prime", {4'd0, filt_temp}, 16'h0F0);
    check("t6_fvalid_prime", {15'd0, filt_valid}, 16'd1);

    // 7: negative values and round-toward-minus-infinity in the average
    mode_in = 1'b1;
    target  = 12'h000;
    do_reset();
    sample(12'hFEF);
    check("t7_filt_neg", {4'd0, filt_temp}, 16'hFEF);
    sample(12'h000);
    check("t7_filt_floor", {4'd0, filt_temp}, 16'hFF3);

    // 8: target+HYST beyond the 12-bit range must not wrap
    mode_in = 1'b1;
    target  = 12'h7F0;
    do_reset();
    tick();
    sample(12'h7F8);
    tick();
    check("t8_B_nowrap", {15'd0, B}, 16'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
